// File: rtl/iomem_fabric.sv
// iomem interconnect: tag-decoded routing to external slaves plus an internal GPIO/pulse/error bank.
// Optional slave-wait timeout enabled by defining IOMEM_FABRIC_TIMEOUT_EN.
module iomem_fabric #(
    parameter int unsigned          NUM_SLV     = 2,
    parameter logic [8*NUM_SLV-1:0] SLV_TAGS    = {8'h08, 8'h04},
    parameter logic [7:0]           GPIO_TAG    = 8'h03,
    parameter int unsigned          GPIO_W      = 8,
    parameter int unsigned          TIMEOUT_CYC = 1024
) (
    input  logic                    i_clk,
    input  logic                    i_rstn,
    input  logic                    i_mem_valid,
    output logic                    o_mem_ready,
    input  logic [3:0]              i_mem_wstrb,
    input  logic [31:0]             i_mem_addr,
    input  logic [31:0]             i_mem_wdata,
    output logic [31:0]             o_mem_rdata,
    output logic [NUM_SLV-1:0]      o_slv_valid,
    input  logic [NUM_SLV-1:0]      i_slv_ready,
    input  logic [32*NUM_SLV-1:0]   i_slv_rdata,
    output logic [31:0]             o_slv_addr,
    output logic [31:0]             o_slv_wdata,
    output logic [3:0]              o_slv_wstrb,
    output logic [GPIO_W-1:0]       o_gpio,
    input  logic [GPIO_W-1:0]       i_gpio,
    output logic [7:0]              o_pulse,
    output logic                    o_err
);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_t;

    state_t              state_q, state_d;
    logic [NUM_SLV-1:0]  sel_q, sel_d;
    logic [31:0]         addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [3:0]          wstrb_q, wstrb_d;
    logic [31:0]         rdata_q, rdata_d;
    logic [GPIO_W-1:0]   gpio_q, gpio_d;
    logic [7:0]          pulse_q, pulse_d;
    logic                err_q, err_d;
    logic                err_set, err_clr;

    logic [NUM_SLV-1:0]  slv_hit;
    logic                slv_found;
    logic                gpio_hit;
    logic [23:0]         gpio_off;
    logic [31:0]         gpio_rd;
    logic [GPIO_W-1:0]   gpio_wr;
    logic [31:0]         sel_rdata;
    logic                sel_ready;

`ifdef IOMEM_FABRIC_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                cnt_expired;

    // Free-running only inside ACCESS, so it is zero on every ACCESS entry.
    always_comb begin
        cnt_d       = (state_q == StAccess) ? cnt_q + 1'b1 : '0;
        cnt_expired = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
    end
`endif

    // Address decode and GPIO read/write data, all from the live request.
    always_comb begin
        slv_hit   = '0;
        slv_found = 1'b0;
        for (int unsigned k = 0; k < NUM_SLV; k++) begin
            if (!slv_found && i_mem_addr[31:24] == SLV_TAGS[8*k +: 8]) begin
                slv_hit[k] = 1'b1;
                slv_found  = 1'b1;
            end
        end
        gpio_hit = !slv_found && (i_mem_addr[31:24] == GPIO_TAG);
        gpio_off = i_mem_addr[23:0];

        gpio_rd = '0;
        case (gpio_off)
            24'h0:   gpio_rd[GPIO_W-1:0] = gpio_q;
            24'h4:   gpio_rd[GPIO_W-1:0] = i_gpio;
            24'hC:   gpio_rd[0]          = err_q;
            default: gpio_rd             = '0;
        endcase

        for (int unsigned i = 0; i < GPIO_W; i++) begin
            gpio_wr[i] = i_mem_wstrb[i/8] ? i_mem_wdata[i] : gpio_q[i];
        end

        sel_rdata = '0;
        for (int unsigned k = 0; k < NUM_SLV; k++) begin
            if (sel_q[k]) begin
                sel_rdata = sel_rdata | i_slv_rdata[32*k +: 32];
            end
        end
        sel_ready = |(i_slv_ready & sel_q);
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        rdata_d = rdata_q;
        gpio_d  = gpio_q;
        pulse_d = '0;
        err_set = 1'b0;
        err_clr = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (i_mem_valid) begin
                    addr_d  = i_mem_addr;
                    wdata_d = i_mem_wdata;
                    wstrb_d = i_mem_wstrb;
                    if (slv_found) begin
                        sel_d   = slv_hit;
                        state_d = StAccess;
                    end else if (gpio_hit) begin
                        rdata_d = gpio_rd;
                        state_d = StResp;
                        if (i_mem_wstrb != 4'b0) begin
                            case (gpio_off)
                                24'h0:   gpio_d = gpio_wr;
                                24'h8:   if (i_mem_wstrb[0]) pulse_d = i_mem_wdata[7:0];
                                24'hC:   err_clr = i_mem_wstrb[0] & i_mem_wdata[0];
                                default: gpio_d = gpio_q;
                            endcase
                        end
                    end else begin
                        rdata_d = '0;
                        err_set = 1'b1;
                        state_d = StResp;
                    end
                end
            end
            StAccess: begin
`ifdef IOMEM_FABRIC_TIMEOUT_EN
                // Ready in the expiry cycle takes priority over the timeout.
                if (sel_ready) begin
                    rdata_d = sel_rdata;
                    state_d = StResp;
                end else if (cnt_expired) begin
                    rdata_d = 32'hDEAD_BEEF;
                    err_set = 1'b1;
                    state_d = StResp;
                end
`else
                if (sel_ready) begin
                    rdata_d = sel_rdata;
                    state_d = StResp;
                end
`endif
            end
            StResp: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        err_d = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q <= StIdle;
            sel_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
            gpio_q  <= '0;
            pulse_q <= '0;
            err_q   <= 1'b0;
`ifdef IOMEM_FABRIC_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            rdata_q <= rdata_d;
            gpio_q  <= gpio_d;
            pulse_q <= pulse_d;
            err_q   <= err_d;
`ifdef IOMEM_FABRIC_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign o_mem_ready = (state_q == StResp);
    assign o_mem_rdata = rdata_q;
    assign o_slv_valid = sel_q & {NUM_SLV{state_q == StAccess}};
    assign o_slv_addr  = addr_q;
    assign o_slv_wdata = wdata_q;
    assign o_slv_wstrb = wstrb_q;
    assign o_gpio      = gpio_q;
    assign o_pulse     = pulse_q;
    assign o_err       = err_q;

endmodule
